param_fifo: RTL
===============

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, meaning storage entries (power of two, >=2).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, meaning almost_full asserts when count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 2, meaning almost_empty asserts when count <= AE_LEVEL.
REQ-005 SHALL have ports: clk in 1 (single clock, all logic on rising edge).
REQ-006 SHALL have port rst in 1: reset, synchronous, active-high.
REQ-007 SHALL have port flush in 1: synchronous clear of contents.
REQ-008 SHALL have ports in_valid in 1, in_data in DATA_W, in_ready out 1: write handshake.
REQ-009 SHALL have ports out_valid out 1, out_data out DATA_W, out_ready in 1: read handshake.
REQ-010 SHALL have ports count out log2(DEPTH)+1, almost_full out 1, almost_empty out 1, buffer_full out 1, buffer_empty out 1, overflow out 1.

Function
REQ-011 SHALL store up to DEPTH words; full means count == DEPTH, with all entries usable (no reserved slot).
REQ-012 SHALL define push = in_valid && in_ready and pop = out_valid && out_ready; a transfer occurs only on the clock edge where its condition is true.
REQ-013 SHALL drive in_ready = !buffer_full; in_ready SHALL NOT depend on out_ready. A push while full is refused even if a pop occurs in the same cycle.
REQ-014 SHALL be first-word-fall-through: out_valid = !buffer_empty, and out_data = the oldest stored word whenever out_valid is high.
REQ-015 SHALL make a word pushed at edge N visible on out_valid/out_data after edge N, with 1-cycle write-to-read latency.
REQ-016 SHALL hold out_data stable while out_valid && !out_ready.
REQ-017 SHALL update count per edge: push only +1; pop only -1; push and pop together, or neither, unchanged.
REQ-018 SHALL allow simultaneous push and pop when 0 < count < DEPTH, preserving order and count.
REQ-019 SHALL ignore a pop request while empty; out_ready with out_valid low has no effect.
REQ-020 SHALL wrap read and write pointers modulo DEPTH with no gap or duplicate at the wrap boundary.
REQ-021 SHALL derive buffer_empty = (count == 0), buffer_full = (count == DEPTH), almost_full = (count >= AF_LEVEL) and almost_empty = (count <= AE_LEVEL) combinationally from registered count.
REQ-022 SHALL set overflow (sticky) on any edge where in_valid && !in_ready; it is cleared only by rst or flush.
REQ-023 SHALL, when flush is high at an edge, reset pointers, count and overflow to 0 and discard any push or pop in that cycle.
REQ-024 SHALL give rst priority over flush, and flush priority over push/pop.
REQ-025 SHALL leave memory contents unreset; only pointers, count and overflow are reset.

Reset
REQ-026 SHALL, at an edge with rst high, set count=0, pointers=0, overflow=0.
REQ-027 SHALL have outputs after reset: buffer_empty=1, out_valid=0, in_ready=1, buffer_full=0, almost_empty=1, almost_full=0.
REQ-028 SHALL make out_data don't-care while out_valid=0.
REQ-029 SHALL, on rst asserted mid-operation, discard stored data, with no transfer occurring on that edge.

Verification
REQ-030 Fill/drain: defaults, push 8 words 0x0001..0x0008 with out_ready=0 -> count=8, buffer_full=1, in_ready=0, almost_full from count 6; then out_ready=1 -> words out in order, buffer_empty after 8 pops.
REQ-031 Overflow: full FIFO, in_valid=1 with 0xDEAD for 1 cycle -> overflow=1, count stays 8, 0xDEAD never output; flush -> overflow=0, count=0.
REQ-032 Simultaneous: count=3, push+pop for 20 cycles with incrementing data -> count stays 3, output strictly in push order, pointers wrap twice without error.
REQ-033 Full plus pop: count=8, in_valid=1 and out_ready=1 same cycle -> pop accepted, push refused, count=7, overflow=1.
REQ-034 Empty pop and latency: empty, out_ready=1 for 3 cycles -> count stays 0; push 0x00A5 at edge N -> out_valid=1 and out_data=0x00A5 after edge N.
REQ-035 Reset mid-stream: count=5, rst high for 1 cycle with in_valid=1 and out_ready=1 -> count=0, buffer_empty=1, no transfer; repeat for DATA_W=8, DEPTH=4 instance.

Source files
------------

// File: rtl/param_fifo.sv
// param_fifo: single-clock first-word-fall-through FIFO with count, level flags and sticky overflow.
// All DEPTH entries are usable; pointers wrap naturally because DEPTH is a power of two.
module param_fifo #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       buffer_full,
    output logic                       buffer_empty,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push, pop;

    assign buffer_empty = count_q == '0;
    assign buffer_full  = count_q == CW'(DEPTH);
    assign almost_full  = count_q >= CW'(AF_LEVEL);
    assign almost_empty = count_q <= CW'(AE_LEVEL);
    assign in_ready     = !buffer_full;
    assign out_valid    = !buffer_empty;
    assign out_data     = mem[rd_ptr_q];
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign push         = in_valid && in_ready;
    assign pop          = out_valid && out_ready;

    always_comb begin
        wr_ptr_d   = flush ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d   = flush ? '0 : rd_ptr_q + AW'(pop);
        count_d    = flush ? '0 : count_q + CW'(push) - CW'(pop);
        overflow_d = flush ? 1'b0 : overflow_q | (in_valid && !in_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left unreset; only writes that survive rst/flush land.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem[wr_ptr_q] <= in_data;
    end
endmodule
